uart_rx_fsm: RTL and testbench
==============================

UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 6, meaning the width of PRESCALE.
REQ-003 SHALL have port CLK, input, 1, the single clock of the block.
REQ-004 SHALL have port RST, input, 1, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port RX_IN, input, 1, the serial line, idle high.
REQ-006 SHALL have port PAR_EN, input, 1, which enables the parity bit in the frame.
REQ-007 SHALL have port PRESCALE, input, PRESCALE_WIDTH, giving oversampling clocks per bit (8, 16 or 32).
REQ-008 SHALL have ports strt_glitch, par_error and stp_error, inputs, 1 each, the registered checker results.
REQ-009 SHALL have port dat_samp_en, output, 1, the data sampler enable.
REQ-010 SHALL have port edge_cnt, output, PRESCALE_WIDTH, the clock position within the current bit.
REQ-011 SHALL have ports strt_chk_en, deser_en, par_chk_en and stp_chk_en, outputs, 1 each, one-cycle strobes.
REQ-012 SHALL have port data_valid, output, 1, a one-cycle pulse for a good frame.
REQ-013 SHALL have port err_cnt, output, 8, the dropped-frame count (see Configuration).

Function
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-015 SHALL latch PRESCALE on the IDLE->START transition, hold it for the rest of the frame, and replace any value other than 8, 16 or 32 with 8.
REQ-016 SHALL move from IDLE to START with edge_cnt=0 when RX_IN is 0.
REQ-017 SHALL, in every state except IDLE, increment edge_cnt each clock and wrap it to 0 after P-1, where P is the latched prescale.
REQ-018 SHALL pulse the check strobe for the current state for one cycle at edge_cnt==P/2+2: strt_chk_en in START, deser_en in DATA, par_chk_en in PARITY, stp_chk_en in STOP.
REQ-019 SHALL hold dat_samp_en high in every state except IDLE.
REQ-020 SHALL sample the checker inputs only at edge_cnt==P-1, the last clock of the bit.
REQ-021 SHALL, in START at edge_cnt==P-1, go to IDLE if strt_glitch is 1 and otherwise go to DATA with bit_cnt=0.
REQ-022 SHALL, in DATA at edge_cnt==P-1, increment bit_cnt.
REQ-023 SHALL, when bit_cnt==DATA_WIDTH-1 in DATA at edge_cnt==P-1, go to PARITY if PAR_EN is 1 and to STOP otherwise.
REQ-024 SHALL sample PAR_EN once, at the DATA->PARITY/STOP decision.
REQ-025 SHALL, in PARITY at edge_cnt==P-1, drop the frame and go to IDLE if par_error is 1, and otherwise go to STOP.
REQ-026 SHALL, in STOP at edge_cnt==P-1, register data_valid=1 for the next cycle if stp_error is 0, and drop the frame if it is 1.
REQ-027 SHALL, on leaving STOP, go directly to START with edge_cnt=0 if RX_IN is 0 (back-to-back frames with no idle clock), and to IDLE otherwise.
REQ-028 SHALL clear edge_cnt and bit_cnt on every state change.
REQ-029 SHALL assert at most one check strobe in any cycle.
REQ-030 SHALL never assert data_valid for a dropped or glitched frame.

Reset
REQ-031 SHALL, on RST low at any time including mid-frame, immediately force state IDLE, edge_cnt=0 and bit_cnt=0.
REQ-032 SHALL, on RST low, force all strobes, dat_samp_en and data_valid to 0, and err_cnt to 0.
REQ-033 SHALL, after RST release, start a frame only on a new RX_IN low seen in IDLE.

Configuration
REQ-034 SHALL compile an 8-bit saturating counter when UART_RX_ERR_CNT_EN is defined; it increments once per frame dropped in PARITY or STOP, holds at 255, and drives err_cnt.
REQ-035 SHALL, when UART_RX_ERR_CNT_EN is not defined, keep the err_cnt port and tie it to 0 with no counter logic; all other behaviour is identical in both builds.

Verification
REQ-036 SHALL check: P=8, PAR_EN=0, byte 0xA5 with good stop -> deser_en pulses 8 times at edge 6 and data_valid pulses once, 80 clocks after the start edge plus 1.
REQ-037 SHALL check: P=16, PAR_EN=1, par_error forced 1 at the parity bit -> return to IDLE, no stp_chk_en and no data_valid, and err_cnt=1 with the macro defined.
REQ-038 SHALL check: RX_IN low for only 3 clocks with strt_glitch=1 -> IDLE at edge 7, no deser_en and no data_valid.
REQ-039 SHALL check: two frames back-to-back at P=32 -> START entered directly from STOP and two data_valid pulses 320 clocks apart.
REQ-040 SHALL check: RST asserted at DATA bit 4, edge 5 -> all outputs 0 that same cycle, and a subsequent clean frame is received correctly.
REQ-041 SHALL check: PRESCALE changed from 8 to 16 mid-frame, then PRESCALE=12 -> the current frame keeps P=8 and the next frame uses P=8.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: frames start/data/parity/stop bits, pulses checker strobes, flags good frames.
// Latency: data_valid rises one clock after the last stop-bit clock; reset is asynchronous and immediate.
// No backpressure: the serial line cannot be stalled. Define UART_RX_ERR_CNT_EN for the dropped-frame counter.
module uart_rx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      strt_glitch,
    input  logic                      par_error,
    input  logic                      stp_error,
    output logic                      dat_samp_en,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic                      strt_chk_en,
    output logic                      deser_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      data_valid,
    output logic [7:0]                err_cnt
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic                      dv_q, dv_d;

    logic [PRESCALE_WIDTH-1:0] presc_norm;
    logic [PRESCALE_WIDTH-1:0] mid_edge;
    logic                      last_edge;

    // Unsupported oversampling ratios fall back to 8.
    assign presc_norm = (PRESCALE == PRESCALE_WIDTH'(16) || PRESCALE == PRESCALE_WIDTH'(32))
                        ? PRESCALE : PRESCALE_WIDTH'(8);
    assign mid_edge   = (presc_q >> 1) + PRESCALE_WIDTH'(2);
    assign last_edge  = (state_q != IDLE) && (edge_q == presc_q - PRESCALE_WIDTH'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            edge_q  <= '0;
            presc_q <= PRESCALE_WIDTH'(8);
            bit_q   <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            presc_q <= presc_d;
            bit_q   <= bit_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        presc_d = presc_q;
        bit_d   = bit_q;
        dv_d    = 1'b0;
        if (state_q != IDLE) begin
            edge_d = last_edge ? '0 : edge_q + PRESCALE_WIDTH'(1);
        end
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d = START;
                    edge_d  = '0;
                    presc_d = presc_norm;
                end
            end
            START: begin
                if (last_edge) begin
                    state_d = strt_glitch ? IDLE : DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (last_edge) begin
                    if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d = PAR_EN ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    state_d = par_error ? IDLE : STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    dv_d = !stp_error;
                    // A low line on the stop-bit boundary is the next start bit.
                    if (!RX_IN) begin
                        state_d = START;
                        presc_d = presc_norm;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dat_samp_en = (state_q != IDLE);
        edge_cnt    = edge_q;
        strt_chk_en = (state_q == START)  && (edge_q == mid_edge);
        deser_en    = (state_q == DATA)   && (edge_q == mid_edge);
        par_chk_en  = (state_q == PARITY) && (edge_q == mid_edge);
        stp_chk_en  = (state_q == STOP)   && (edge_q == mid_edge);
        data_valid  = dv_q;
    end

`ifdef UART_RX_ERR_CNT_EN
    logic       drop;
    logic [7:0] err_q;

    assign drop = last_edge && (((state_q == PARITY) && par_error) ||
                                ((state_q == STOP) && stp_error));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= '0;
        end else if (drop && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frame timing, strobes, drops, glitches, back-to-back frames and reset.
module tb_uart_rx_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] PRESCALE = 6'd8;
    logic       strt_glitch = 1'b0;
    logic       par_error = 1'b0;
    logic       stp_error = 1'b0;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic       strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid;
    logic [7:0] err_cnt;

`ifdef UART_RX_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PRESCALE(PRESCALE),
        .strt_glitch(strt_glitch), .par_error(par_error), .stp_error(stp_error),
        .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .strt_chk_en(strt_chk_en),
        .deser_en(deser_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .data_valid(data_valid), .err_cnt(err_cnt)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int t0 = 0;

    // Event monitor; tasks request a clear by bumping clr_gen.
    int n_strt, n_deser, n_par, n_stp, n_dv, n_busy, n_drop, n_multi, n_bad_edge;
    int dv_first, dv_last;
    int exp_mid = 6;
    int clr_gen = 0;
    int clr_seen = 0;
    bit prev_samp = 1'b0;

    always @(negedge CLK) begin
        if (clr_seen != clr_gen) begin
            n_strt = 0; n_deser = 0; n_par = 0; n_stp = 0; n_dv = 0;
            n_busy = 0; n_drop = 0; n_multi = 0; n_bad_edge = 0;
            dv_first = -1; dv_last = -1;
            clr_seen = clr_gen;
        end
        if (strt_chk_en) n_strt++;
        if (deser_en) n_deser++;
        if (par_chk_en) n_par++;
        if (stp_chk_en) n_stp++;
        if ((strt_chk_en | deser_en | par_chk_en | stp_chk_en) && (int'(edge_cnt) != exp_mid)) n_bad_edge++;
        if ((int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en) + int'(stp_chk_en)) > 1) n_multi++;
        if (data_valid) begin
            if (n_dv == 0) dv_first = cyc;
            dv_last = cyc;
            n_dv++;
        end
        if (dat_samp_en) n_busy++;
        if (prev_samp && !dat_samp_en) n_drop++;
        prev_samp = dat_samp_en;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_mon(input int mid);
        exp_mid = mid;
        clr_gen++;
    endtask

    // Drives one frame with bit period p; returns one clock after the last stop-bit clock.
    task automatic send_frame(input int p, input logic [7:0] d, input logic pe, input logic pb);
        t0 = cyc;
        RX_IN = 1'b0;
        step(p);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            step(p);
        end
        if (pe) begin
            RX_IN = pb;
            step(p);
        end
        RX_IN = 1'b1;
        step(p);
    endtask

    task automatic test_reset;
        #2;
        total_cnt++; if (dat_samp_en !== 1'b0) $display("FAIL rst_samp_en: got %b want 0", dat_samp_en); else pass_cnt++;
        total_cnt++; if (edge_cnt !== 6'd0) $display("FAIL rst_edge_cnt: got %0d want 0", edge_cnt); else pass_cnt++;
        total_cnt++; if ({strt_chk_en, deser_en, par_chk_en, stp_chk_en} !== 4'b0) $display("FAIL rst_strobes: got %b want 0000", {strt_chk_en, deser_en, par_chk_en, stp_chk_en}); else pass_cnt++;
        total_cnt++; if (data_valid !== 1'b0) $display("FAIL rst_data_valid: got %b want 0", data_valid); else pass_cnt++;
        total_cnt++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
        step(2);
        RST = 1'b1;
        step(4);
        total_cnt++; if (dat_samp_en !== 1'b0) $display("FAIL idle_after_rst: got %b want 0", dat_samp_en); else pass_cnt++;
    endtask

    task automatic test_basic_p8;
        PRESCALE = 6'd8; PAR_EN = 1'b0;
        start_mon(6);
        send_frame(8, 8'hA5, 1'b0, 1'b0);
        step(5);
        total_cnt++; if (n_deser !== 8) $display("FAIL basic_deser_cnt: got %0d want 8", n_deser); else pass_cnt++;
        total_cnt++; if (n_bad_edge !== 0) $display("FAIL basic_strobe_edge: got %0d off-edge strobes want 0", n_bad_edge); else pass_cnt++;
        total_cnt++; if (n_dv !== 1) $display("FAIL basic_dv_cnt: got %0d want 1", n_dv); else pass_cnt++;
        total_cnt++; if (dv_first !== t0 + 81) $display("FAIL basic_dv_time: got %0d want %0d", dv_first - t0, 81); else pass_cnt++;
        total_cnt++; if (n_strt !== 1 || n_stp !== 1 || n_par !== 0) $display("FAIL basic_chk_cnts: got strt %0d stp %0d par %0d want 1 1 0", n_strt, n_stp, n_par); else pass_cnt++;
        total_cnt++; if (n_multi !== 0) $display("FAIL basic_multi_strobe: got %0d want 0", n_multi); else pass_cnt++;
        total_cnt++; if (n_busy !== 80) $display("FAIL basic_busy: got %0d want 80", n_busy); else pass_cnt++;
        total_cnt++; if (dat_samp_en !== 1'b0) $display("FAIL basic_back_idle: got %b want 0", dat_samp_en); else pass_cnt++;
        total_cnt++; if (err_cnt !== 8'd0) $display("FAIL basic_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
    endtask

    task automatic test_parity_error;
        PRESCALE = 6'd16; PAR_EN = 1'b1; par_error = 1'b1;
        start_mon(10);
        send_frame(16, 8'h3C, 1'b1, 1'b0);
        step(5);
        par_error = 1'b0; PAR_EN = 1'b0;
        total_cnt++; if (n_par !== 1) $display("FAIL par_chk_cnt: got %0d want 1", n_par); else pass_cnt++;
        total_cnt++; if (n_stp !== 0) $display("FAIL par_no_stp: got %0d want 0", n_stp); else pass_cnt++;
        total_cnt++; if (n_dv !== 0) $display("FAIL par_no_dv: got %0d want 0", n_dv); else pass_cnt++;
        total_cnt++; if (n_busy !== 160) $display("FAIL par_busy: got %0d want 160", n_busy); else pass_cnt++;
        total_cnt++; if (n_bad_edge !== 0 || n_deser !== 8) $display("FAIL par_strobes: got bad %0d deser %0d want 0 8", n_bad_edge, n_deser); else pass_cnt++;
        total_cnt++; if (err_cnt !== (ERR_EN ? 8'd1 : 8'd0)) $display("FAIL par_err_cnt: got %0d want %0d", err_cnt, ERR_EN ? 1 : 0); else pass_cnt++;
    endtask

    task automatic test_glitch;
        PRESCALE = 6'd8; strt_glitch = 1'b1;
        start_mon(6);
        RX_IN = 1'b0;
        step(3);
        RX_IN = 1'b1;
        step(20);
        strt_glitch = 1'b0;
        total_cnt++; if (n_strt !== 1 || n_bad_edge !== 0) $display("FAIL glitch_strt: got cnt %0d bad %0d want 1 0", n_strt, n_bad_edge); else pass_cnt++;
        total_cnt++; if (n_busy !== 8) $display("FAIL glitch_idle_at_edge7: got busy %0d want 8", n_busy); else pass_cnt++;
        total_cnt++; if (n_deser !== 0 || n_dv !== 0) $display("FAIL glitch_no_data: got deser %0d dv %0d want 0 0", n_deser, n_dv); else pass_cnt++;
        total_cnt++; if (err_cnt !== (ERR_EN ? 8'd1 : 8'd0)) $display("FAIL glitch_err_cnt: got %0d want %0d", err_cnt, ERR_EN ? 1 : 0); else pass_cnt++;
    endtask

    task automatic test_stop_error;
        PRESCALE = 6'd8; stp_error = 1'b1;
        start_mon(6);
        send_frame(8, 8'h0F, 1'b0, 1'b0);
        step(5);
        stp_error = 1'b0;
        total_cnt++; if (n_stp !== 1 || n_deser !== 8) $display("FAIL stp_strobes: got stp %0d deser %0d want 1 8", n_stp, n_deser); else pass_cnt++;
        total_cnt++; if (n_dv !== 0) $display("FAIL stp_no_dv: got %0d want 0", n_dv); else pass_cnt++;
        total_cnt++; if (err_cnt !== (ERR_EN ? 8'd2 : 8'd0)) $display("FAIL stp_err_cnt: got %0d want %0d", err_cnt, ERR_EN ? 2 : 0); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int t_first;
        PRESCALE = 6'd32;
        start_mon(18);
        send_frame(32, 8'h55, 1'b0, 1'b0);
        t_first = t0;
        send_frame(32, 8'hAA, 1'b0, 1'b0);
        step(5);
        total_cnt++; if (n_strt !== 2) $display("FAIL b2b_strt_cnt: got %0d want 2", n_strt); else pass_cnt++;
        total_cnt++; if (n_drop !== 1) $display("FAIL b2b_no_idle_gap: got %0d busy drops want 1", n_drop); else pass_cnt++;
        total_cnt++; if (n_busy !== 640) $display("FAIL b2b_busy: got %0d want 640", n_busy); else pass_cnt++;
        total_cnt++; if (n_dv !== 2) $display("FAIL b2b_dv_cnt: got %0d want 2", n_dv); else pass_cnt++;
        total_cnt++; if (dv_first !== t_first + 321) $display("FAIL b2b_dv_first: got %0d want %0d", dv_first - t_first, 321); else pass_cnt++;
        total_cnt++; if (dv_last - dv_first !== 320) $display("FAIL b2b_dv_gap: got %0d want 320", dv_last - dv_first); else pass_cnt++;
        total_cnt++; if (n_deser !== 16 || n_bad_edge !== 0) $display("FAIL b2b_deser: got %0d bad %0d want 16 0", n_deser, n_bad_edge); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        PRESCALE = 6'd8;
        start_mon(6);
        t0 = cyc;
        RX_IN = 1'b0;
        step(8);
        RX_IN = 1'b1;
        step(38);
        total_cnt++; if (edge_cnt !== 6'd5 || dat_samp_en !== 1'b1) $display("FAIL mid_pre_rst: got edge %0d samp %b want 5 1", edge_cnt, dat_samp_en); else pass_cnt++;
        total_cnt++; if (n_deser !== 4) $display("FAIL mid_pre_rst_bits: got %0d want 4", n_deser); else pass_cnt++;
        RST = 1'b0;
        #1;
        total_cnt++; if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) $display("FAIL mid_rst_now: got samp %b edge %0d want 0 0", dat_samp_en, edge_cnt); else pass_cnt++;
        total_cnt++; if ({strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid} !== 5'b0) $display("FAIL mid_rst_strobes: got %b want 00000", {strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid}); else pass_cnt++;
        total_cnt++; if (err_cnt !== 8'd0) $display("FAIL mid_rst_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
        step(2);
        RST = 1'b1;
        step(3);
        start_mon(6);
        send_frame(8, 8'h3C, 1'b0, 1'b0);
        step(5);
        total_cnt++; if (n_dv !== 1 || dv_first !== t0 + 81) $display("FAIL mid_clean_frame: got dv %0d at %0d want 1 at 81", n_dv, dv_first - t0); else pass_cnt++;
        total_cnt++; if (n_deser !== 8 || n_strt !== 1) $display("FAIL mid_clean_strobes: got deser %0d strt %0d want 8 1", n_deser, n_strt); else pass_cnt++;
    endtask

    task automatic test_prescale_latch;
        PRESCALE = 6'd8;
        start_mon(6);
        fork
            send_frame(8, 8'hC3, 1'b0, 1'b0);
            begin
                step(20);
                PRESCALE = 6'd16;
            end
        join
        step(5);
        total_cnt++; if (n_dv !== 1 || dv_first !== t0 + 81) $display("FAIL latch_keep_p8: got dv %0d at %0d want 1 at 81", n_dv, dv_first - t0); else pass_cnt++;
        total_cnt++; if (n_busy !== 80 || n_bad_edge !== 0) $display("FAIL latch_keep_busy: got %0d bad %0d want 80 0", n_busy, n_bad_edge); else pass_cnt++;
        PRESCALE = 6'd12; PAR_EN = 1'b1;
        start_mon(6);
        send_frame(8, 8'h81, 1'b1, 1'b0);
        step(5);
        PAR_EN = 1'b0;
        total_cnt++; if (n_dv !== 1 || dv_first !== t0 + 89) $display("FAIL latch_p12_as_p8: got dv %0d at %0d want 1 at 89", n_dv, dv_first - t0); else pass_cnt++;
        total_cnt++; if (n_par !== 1 || n_bad_edge !== 0) $display("FAIL latch_p12_par: got par %0d bad %0d want 1 0", n_par, n_bad_edge); else pass_cnt++;
        total_cnt++; if (n_busy !== 88) $display("FAIL latch_p12_busy: got %0d want 88", n_busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_p8();
        test_parity_error();
        test_glitch();
        test_stop_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_prescale_latch();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
